// File: rtl/atm_keypad_entry_if.sv
// Keypad/controller signal bundle for atm_keypad_entry.
// master = keypad/controller side (drives keys and PIN verdicts),
// slave  = the entry block itself.
interface atm_keypad_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        pin_ok;
    logic        pin_reject;
    logic        session_end;
    logic [11:0] Account_Number;
    logic [11:0] PIN;
    logic        acct_valid;
    logic        pin_valid;
    logic        locked;
    logic [2:0]  tries;
    logic        timeout;

    modport master (
        output key_valid, key_code, pin_ok, pin_reject, session_end,
        input  Account_Number, PIN, acct_valid, pin_valid, locked, tries, timeout
    );

    modport slave (
        input  key_valid, key_code, pin_ok, pin_reject, session_end,
        output Account_Number, PIN, acct_valid, pin_valid, locked, tries, timeout
    );
endinterface

// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: assembles 3-digit BCD account/PIN words from keypad
// strokes, strobes them to the ATM controller, counts PIN rejections and
// locks the keypad out for LOCK_CYCLES clocks after MAX_TRIES rejections.
// Optional macro KEYPAD_TIMEOUT_EN adds an inactivity abort (timeout pulse).
module atm_keypad_entry #(
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic              clk,
    input  logic              rst,   // asynchronous, active-low
    atm_keypad_entry_if.slave kp
);
    localparam logic [2:0] S_ACCT = 3'd0;
    localparam logic [2:0] S_PIN  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_LOCK = 3'd4;

    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    // Out-of-range parameters leave this marker block in the elaborated
    // hierarchy; legal settings produce nothing.
    localparam bit CFG_OK = (MAX_TRIES >= 1) && (MAX_TRIES <= 7) &&
                            (LOCK_CYCLES >= 1) && (TIMEOUT_CYCLES >= 2);
    if (!CFG_OK) begin : g_cfg_out_of_range
    end

    logic [2:0]    r_state;
    logic [11:0]   r_ent;
    logic [1:0]    r_cnt;
    logic [11:0]   r_acct;
    logic [11:0]   r_pin;
    logic          r_acct_vld;
    logic          r_pin_vld;
    logic [2:0]    r_tries;
    logic [LW-1:0] r_lock_cnt;

    logic       w_is_digit;
    logic       w_is_clr;
    logic       w_is_bs;
    logic       w_is_ent;
    logic [2:0] w_tries_nx;
    logic       w_se;
    logic       w_to_fire;

    assign w_is_digit = (kp.key_code <= 4'd9);
    assign w_is_clr   = (kp.key_code == 4'hA);
    assign w_is_bs    = (kp.key_code == 4'hB);
    assign w_is_ent   = (kp.key_code == 4'hE);
    assign w_tries_nx = r_tries + 3'd1;
    // session_end is honoured everywhere except during lockout
    assign w_se       = kp.session_end && (r_state != S_LOCK);

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] r_idle;
    logic          r_timeout;
    logic          w_idle_run;

    // Idle time only matters while a customer is mid-entry.
    assign w_idle_run = (r_state == S_PIN) || ((r_state == S_ACCT) && (r_cnt != 2'd0));
    // A key in the same cycle restarts the wait; session_end outranks the abort.
    assign w_to_fire  = w_idle_run && !kp.key_valid && !kp.session_end &&
                        (r_idle == TW'(TIMEOUT_CYCLES - 1));

    // Inactivity counter and the registered timeout pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            if (!w_idle_run || kp.key_valid || kp.session_end || w_to_fire)
                r_idle <= '0;
            else
                r_idle <= r_idle + TW'(1);
        end
    end

    assign kp.timeout = r_timeout;
`else
    assign w_to_fire  = 1'b0;
    assign kp.timeout = 1'b0;
`endif

    // Entry FSM: digit assembly, word hand-off, reject counting, lockout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_ACCT;
            r_ent      <= '0;
            r_cnt      <= '0;
            r_acct     <= '0;
            r_pin      <= '0;
            r_acct_vld <= 1'b0;
            r_pin_vld  <= 1'b0;
            r_tries    <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_acct_vld <= 1'b0;
            r_pin_vld  <= 1'b0;
            if (w_se) begin
                r_state <= S_ACCT;
                r_ent   <= '0;
                r_cnt   <= '0;
                r_tries <= '0;
                r_acct  <= '0;
                r_pin   <= '0;
            end else if (w_to_fire) begin
                // inactivity abort keeps the rejection count
                r_state <= S_ACCT;
                r_ent   <= '0;
                r_cnt   <= '0;
                r_acct  <= '0;
                r_pin   <= '0;
            end else begin
                case (r_state)
                    S_ACCT, S_PIN: begin
                        if (kp.key_valid) begin
                            if (w_is_digit) begin
                                if (r_cnt != 2'd3) begin
                                    r_ent <= {r_ent[7:0], kp.key_code};
                                    r_cnt <= r_cnt + 2'd1;
                                end
                            end else if (w_is_bs) begin
                                if (r_cnt != 2'd0) begin
                                    r_ent <= {4'h0, r_ent[11:4]};
                                    r_cnt <= r_cnt - 2'd1;
                                end
                            end else if (w_is_clr) begin
                                r_ent <= '0;
                                r_cnt <= '0;
                            end else if (w_is_ent && (r_cnt == 2'd3)) begin
                                // word and strobe register on the same edge
                                if (r_state == S_ACCT) begin
                                    r_acct     <= r_ent;
                                    r_acct_vld <= 1'b1;
                                    r_state    <= S_PIN;
                                end else begin
                                    r_pin     <= r_ent;
                                    r_pin_vld <= 1'b1;
                                    r_state   <= S_WAIT;
                                end
                                r_ent <= '0;
                                r_cnt <= '0;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (kp.pin_ok) begin
                            r_state <= S_DONE;
                            r_tries <= '0;
                        end else if (kp.pin_reject) begin
                            r_tries <= w_tries_nx;
                            if (w_tries_nx == 3'(MAX_TRIES)) begin
                                r_state    <= S_LOCK;
                                r_lock_cnt <= LW'(LOCK_CYCLES - 1);
                            end else begin
                                r_state <= S_PIN;
                            end
                        end
                    end
                    S_DONE: begin
                        // idle until session_end
                    end
                    S_LOCK: begin
                        if (r_lock_cnt == '0) begin
                            r_state <= S_ACCT;
                            r_tries <= '0;
                            r_acct  <= '0;
                            r_pin   <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt - LW'(1);
                        end
                    end
                    default: r_state <= S_ACCT;
                endcase
            end
        end
    end

    assign kp.Account_Number = r_acct;
    assign kp.PIN            = r_pin;
    assign kp.acct_valid     = r_acct_vld;
    assign kp.pin_valid      = r_pin_vld;
    assign kp.locked         = (r_state == S_LOCK);
    assign kp.tries          = r_tries;
endmodule
